// File: rtl/ifu_prefetch_pkg.sv
// Shared core constants for the instruction fetch path.
package ifu_prefetch_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;
  localparam logic [XLEN-1:0] RESET_VECTOR_DEF = '0;

endpackage

// File: rtl/ifu_prefetch_sync_fifo.sv
// Synchronous FIFO with flush; a push reaches the head one cycle later (no bypass).
// Push while full is accepted only with a simultaneous pop; pop while empty is ignored.
module ifu_prefetch_sync_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 32,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             i_core_clk,
  input  logic             i_arst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_dat,
  input  logic             i_pop,
  input  logic             i_flush,
  output logic [WIDTH-1:0] o_head_dat,
  output logic [CW-1:0]    o_count,
  output logic             o_empty,
  output logic             o_full
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign o_empty    = (r_count == '0);
  assign o_full     = (r_count == CW'(DEPTH));
  assign o_count    = r_count;
  assign o_head_dat = r_mem[r_rd_ptr];

  assign w_pop  = i_pop & ~o_empty;
  assign w_push = i_push & (~o_full | w_pop);

  always_ff @(posedge i_core_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge i_core_clk) begin
    if (w_push && !i_flush) r_mem[r_wr_ptr] <= i_push_dat;
  end

endmodule

// File: rtl/ifu_prefetch.sv
// Sequential instruction prefetcher: credit-limited requests, in-order responses queued for decode.
// Head data appears one cycle after its response; decode stalls via ir_ready_in, memory via credits.
module ifu_prefetch
  import ifu_prefetch_pkg::*;
#(
  parameter int                    ADDR_WIDTH   = XLEN,
  parameter int                    DATA_WIDTH   = ILEN,
  parameter int                    DEPTH        = 4,
  parameter int                    INC          = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = ADDR_WIDTH'(RESET_VECTOR_DEF)
) (
  input  logic                  ifu_clock_in,
  input  logic                  ifu_reset_in,
  input  logic                  branch_valid_in,
  input  logic [ADDR_WIDTH-1:0] branch_addr_in,
  input  logic                  jump_valid_in,
  input  logic [ADDR_WIDTH-1:0] jump_addr_in,
  output logic                  mem_req_valid_out,
  output logic [ADDR_WIDTH-1:0] mem_req_addr_out,
  input  logic                  mem_req_ready_in,
  input  logic                  mem_rsp_valid_in,
  input  logic [DATA_WIDTH-1:0] mem_rsp_data_in,
  output logic                  ir_valid_out,
  output logic [DATA_WIDTH-1:0] ir_data_out,
  output logic [ADDR_WIDTH-1:0] ir_pc_out,
  input  logic                  ir_ready_in
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

  logic [ADDR_WIDTH-1:0] r_fetch_pc;
  logic [ADDR_WIDTH-1:0] r_head_pc;
  logic [CW-1:0]         r_outstanding;
  logic [CW-1:0]         r_drop_cnt;
  logic                  r_run;

  logic                  w_redirect;
  logic [ADDR_WIDTH-1:0] w_target;
  logic                  w_credit;
  logic                  w_req_fire;
  logic                  w_deq_fire;
  logic                  w_rsp_ok;
  logic                  w_rsp_drop;
  logic                  w_push;
  logic [CW-1:0]         w_count;
  logic [CW-1:0]         w_out_nxt;
  logic                  w_empty;
  logic                  w_full;

  assign w_redirect = branch_valid_in | jump_valid_in;
  assign w_target   = branch_valid_in ? branch_addr_in : jump_addr_in;

  // Every in-flight request owns a queue slot, so responses never need backpressure.
  assign w_credit          = ({1'b0, r_outstanding} + {1'b0, w_count}) < DEPTH_C;
  assign mem_req_valid_out = r_run & ~w_redirect & w_credit;
  assign mem_req_addr_out  = r_fetch_pc;
  assign w_req_fire        = mem_req_valid_out & mem_req_ready_in;

  assign ir_valid_out = ~w_empty;
  assign ir_pc_out    = r_head_pc;
  assign w_deq_fire   = ir_valid_out & ir_ready_in;

  assign w_rsp_ok   = mem_rsp_valid_in & (r_outstanding != '0);
  assign w_rsp_drop = (r_drop_cnt != '0) | w_redirect;
  assign w_push     = w_rsp_ok & ~w_rsp_drop;
  assign w_out_nxt  = r_outstanding + CW'(w_req_fire) - CW'(w_rsp_ok);

  ifu_prefetch_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (DATA_WIDTH)
  ) u_queue (
    .i_core_clk (ifu_clock_in),
    .i_arst_n   (ifu_reset_in),
    .i_push     (w_push),
    .i_push_dat (mem_rsp_data_in),
    .i_pop      (w_deq_fire),
    .i_flush    (w_redirect),
    .o_head_dat (ir_data_out),
    .o_count    (w_count),
    .o_empty    (w_empty),
    .o_full     (w_full)
  );

  always_ff @(posedge ifu_clock_in or negedge ifu_reset_in) begin
    if (!ifu_reset_in) begin
      r_fetch_pc    <= RESET_VECTOR;
      r_head_pc     <= RESET_VECTOR;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
      r_run         <= 1'b0;
    end else begin
      r_run         <= 1'b1;
      r_outstanding <= w_out_nxt;
      if (w_redirect) begin
        // Everything still in flight belongs to the abandoned stream.
        r_fetch_pc <= w_target;
        r_head_pc  <= w_target;
        r_drop_cnt <= w_out_nxt;
      end else begin
        if (w_req_fire) r_fetch_pc <= r_fetch_pc + ADDR_WIDTH'(INC);
        if (w_deq_fire) r_head_pc  <= r_head_pc + ADDR_WIDTH'(INC);
        if (w_rsp_ok && (r_drop_cnt != '0)) r_drop_cnt <= r_drop_cnt - CW'(1);
      end
    end
  end

  a_rsp_without_request: assert property (@(posedge ifu_clock_in) disable iff (!ifu_reset_in)
    !(mem_rsp_valid_in && (r_outstanding == '0)));

  a_queue_overflow: assert property (@(posedge ifu_clock_in) disable iff (!ifu_reset_in)
    !(w_push && w_full && !w_deq_fire));

endmodule

// File: tb/tb_ifu_prefetch.sv
// Directed bench for ifu_prefetch: queue-level reference model compared every cycle, plus literal pins.
module tb_ifu_prefetch;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int INC   = 4;

  localparam int PK_REQVLD  = 0;
  localparam int PK_REQ     = 1;
  localparam int PK_IRVLD   = 2;
  localparam int PK_IR      = 3;
  localparam int PK_TIMEOUT = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          branch_vld = 1'b0;
  logic [AW-1:0] baddr = '0;
  logic          jump_vld = 1'b0;
  logic [AW-1:0] jaddr = '0;
  logic          mem_req_valid_out;
  logic [AW-1:0] mem_req_addr_out;
  logic          mem_ready = 1'b0;
  logic          mem_rsp_vld = 1'b0;
  logic [DW-1:0] mem_rsp_dat = '0;
  logic          ir_valid_out;
  logic [DW-1:0] ir_data_out;
  logic [AW-1:0] ir_pc_out;
  logic          ir_ready = 1'b0;

  ifu_prefetch #(
    .ADDR_WIDTH   (AW),
    .DATA_WIDTH   (DW),
    .DEPTH        (DEPTH),
    .INC          (INC),
    .RESET_VECTOR ('0)
  ) dut (
    .ifu_clock_in      (clk),
    .ifu_reset_in      (rst_n),
    .branch_valid_in   (branch_vld),
    .branch_addr_in    (baddr),
    .jump_valid_in     (jump_vld),
    .jump_addr_in      (jaddr),
    .mem_req_valid_out (mem_req_valid_out),
    .mem_req_addr_out  (mem_req_addr_out),
    .mem_req_ready_in  (mem_ready),
    .mem_rsp_valid_in  (mem_rsp_vld),
    .mem_rsp_data_in   (mem_rsp_dat),
    .ir_valid_out      (ir_valid_out),
    .ir_data_out       (ir_data_out),
    .ir_pc_out         (ir_pc_out),
    .ir_ready_in       (ir_ready)
  );

  always #5 clk = ~clk;

  // Reference model: requests in flight (with drop marking) and instructions waiting for decode.
  typedef struct { logic [AW-1:0] addr; logic keep; int due; } fl_t;
  typedef struct { logic [AW-1:0] pc; logic [DW-1:0] dat; } ir_t;

  fl_t           fl[$];
  ir_t           irq[$];
  logic [AW-1:0] m_fetch_pc = '0;
  logic          m_run = 1'b0;
  int            cyc = 0;
  int            mem_lat = 1;

  int n_checks = 0;
  int n_fails  = 0;

  logic          pin_en = 1'b0;
  int            pin_kind = 0;
  logic [31:0]   pin_exp = '0;
  logic [31:0]   pin_exp2 = '0;
  string         pin_name = "";

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  function automatic logic exp_req_vld();
    return m_run && !(branch_vld || jump_vld) && ((fl.size() + irq.size()) < DEPTH);
  endfunction

  always @(posedge clk) begin
    logic redirect;
    logic rq;
    logic dq;
    fl_t  f;
    cyc++;
    if (!rst_n) begin
      fl.delete();
      irq.delete();
      m_fetch_pc = '0;
      m_run      = 1'b0;
    end else begin
      redirect = branch_vld || jump_vld;
      rq = exp_req_vld() && mem_ready;
      dq = (irq.size() != 0) && ir_ready;
      if (dq) void'(irq.pop_front());
      if (mem_rsp_vld && fl.size() != 0) begin
        f = fl.pop_front();
        if (f.keep && !redirect) irq.push_back('{f.addr, mem_word(f.addr)});
      end
      if (rq) begin
        fl.push_back('{m_fetch_pc, 1'b1, cyc + mem_lat - 1});
        m_fetch_pc = m_fetch_pc + INC;
      end
      if (redirect) begin
        irq.delete();
        foreach (fl[i]) fl[i].keep = 1'b0;
        m_fetch_pc = branch_vld ? baddr : jaddr;
      end
      m_run = 1'b1;
    end
    #1;
    if (rst_n && fl.size() != 0 && fl[0].due <= cyc) begin
      mem_rsp_vld = 1'b1;
      mem_rsp_dat = mem_word(fl[0].addr);
    end else begin
      mem_rsp_vld = 1'b0;
      mem_rsp_dat = '0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    logic ev_req;
    logic ev_ir;
    ev_req = rst_n ? exp_req_vld() : 1'b0;
    ev_ir  = rst_n ? (irq.size() != 0) : 1'b0;
    chk("req_valid", 32'(mem_req_valid_out), 32'(ev_req));
    if (ev_req) chk("req_addr", mem_req_addr_out, m_fetch_pc);
    chk("ir_valid", 32'(ir_valid_out), 32'(ev_ir));
    if (ev_ir) begin
      chk("ir_pc", ir_pc_out, irq[0].pc);
      chk("ir_data", ir_data_out, irq[0].dat);
    end
    if (pin_en) begin
      case (pin_kind)
        PK_REQVLD: chk({pin_name, "/req_valid"}, 32'(mem_req_valid_out), pin_exp);
        PK_REQ: begin
          chk({pin_name, "/req_valid"}, 32'(mem_req_valid_out), 32'd1);
          chk({pin_name, "/req_addr"}, mem_req_addr_out, pin_exp);
        end
        PK_IRVLD: chk({pin_name, "/ir_valid"}, 32'(ir_valid_out), pin_exp);
        PK_IR: begin
          chk({pin_name, "/ir_valid"}, 32'(ir_valid_out), 32'd1);
          chk({pin_name, "/ir_pc"}, ir_pc_out, pin_exp);
          chk({pin_name, "/ir_data"}, ir_data_out, pin_exp2);
        end
        default: begin
          n_checks++;
          n_fails++;
          $display("FAIL %s: ir_valid_out still 0 after cycle budget, required 1", pin_name);
        end
      endcase
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pin(input int k, input logic [31:0] e, input logic [31:0] e2, input string nm);
    pin_kind = k;
    pin_exp  = e;
    pin_exp2 = e2;
    pin_name = nm;
    pin_en   = 1'b1;
    @(negedge clk);
    #1;
    pin_en = 1'b0;
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    branch_vld = 1'b0;
    jump_vld   = 1'b0;
    tick(2);
    rst_n = 1'b1;
  endtask

  task automatic wait_irv(input int budget, input string nm);
    int n = 0;
    while (!ir_valid_out && n < budget) begin
      tick(1);
      n++;
    end
    if (!ir_valid_out) pin(PK_TIMEOUT, '0, '0, nm);
  endtask

  initial begin
    // Reset state.
    tick(1);
    pin(PK_REQVLD, 0, 0, "rst_req");
    tick(1);
    pin(PK_IRVLD, 0, 0, "rst_ir");

    // 1: streaming, one instruction per cycle.
    mem_ready = 1'b1; ir_ready = 1'b1; mem_lat = 1;
    tick(1);
    do_reset();
    pin(PK_REQVLD, 0, 0, "t1_first_edge");
    tick(1);
    pin(PK_REQ, 32'h0, 0, "t1_req0");
    tick(2);
    pin(PK_IR, 32'h0, 32'hC0DE_0000, "t1_ir0");
    tick(1);
    pin(PK_IR, 32'h4, 32'hC0DE_0004, "t1_ir4");
    tick(1);
    pin(PK_IR, 32'h8, 32'hC0DE_0008, "t1_ir8");
    tick(6);

    // 2: decode stalled, credits exhausted after four requests.
    ir_ready = 1'b0;
    do_reset();
    tick(8);
    pin(PK_REQVLD, 0, 0, "t2_credit_stop");
    tick(1);
    pin(PK_IR, 32'h0, 32'hC0DE_0000, "t2_head");
    tick(1);
    ir_ready = 1'b1;
    tick(1);
    ir_ready = 1'b0;
    pin(PK_REQ, 32'h10, 0, "t2_refill");
    tick(1);
    pin(PK_REQVLD, 0, 0, "t2_restop");
    tick(1);
    pin(PK_IR, 32'h4, 32'hC0DE_0004, "t2_head4");

    // 3: branch with three requests in flight at latency 5.
    ir_ready = 1'b1; mem_lat = 5;
    tick(1);
    do_reset();
    tick(4);
    branch_vld = 1'b1; baddr = 32'h100;
    pin(PK_REQVLD, 0, 0, "t3_gate");
    tick(1);
    branch_vld = 1'b0;
    pin(PK_REQ, 32'h100, 0, "t3_target");
    wait_irv(40, "t3_wait");
    pin(PK_IR, 32'h100, 32'hC0DE_0100, "t3_first");
    tick(12);

    // 4: branch beats jump in the same cycle.
    mem_lat = 1;
    tick(1);
    do_reset();
    tick(3);
    branch_vld = 1'b1; baddr = 32'h200;
    jump_vld   = 1'b1; jaddr = 32'h300;
    tick(1);
    branch_vld = 1'b0; jump_vld = 1'b0;
    pin(PK_REQ, 32'h200, 0, "t4_branch_wins");
    wait_irv(20, "t4_wait");
    pin(PK_IR, 32'h200, 32'hC0DE_0200, "t4_first");
    tick(6);

    // 5: address wrap via jump near the top of the address space.
    ir_ready = 1'b0;
    do_reset();
    tick(1);
    jump_vld = 1'b1; jaddr = 32'hFFFF_FFF8;
    tick(1);
    jump_vld = 1'b0;
    pin(PK_REQ, 32'hFFFF_FFF8, 0, "t5_reqF8");
    tick(1);
    pin(PK_REQ, 32'hFFFF_FFFC, 0, "t5_reqFC");
    tick(1);
    pin(PK_REQ, 32'h0, 0, "t5_wrap");
    tick(3);
    pin(PK_IR, 32'hFFFF_FFF8, 32'h3F21_FFF8, "t5_headF8");
    tick(1);
    ir_ready = 1'b1;
    tick(2);
    ir_ready = 1'b0;
    pin(PK_IR, 32'h0, 32'hC0DE_0000, "t5_head_wrap");

    // 6: reset with two queued and two in flight.
    mem_lat = 5;
    tick(1);
    do_reset();
    tick(8);
    rst_n = 1'b0;
    pin(PK_IRVLD, 0, 0, "t6_ir_drop");
    tick(1);
    pin(PK_REQVLD, 0, 0, "t6_req_drop");
    mem_lat = 1;
    tick(1);
    rst_n = 1'b1;
    tick(1);
    pin(PK_REQ, 32'h0, 0, "t6_restart");
    tick(8);
    pin(PK_REQVLD, 0, 0, "t6_four_only");
    tick(1);
    pin(PK_IR, 32'h0, 32'hC0DE_0000, "t6_head");
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
